// File: rtl/serial_adder.sv
//==============================================================================
// Module   : serial_adder
// Brief    : Digit-serial adder. Sums two WIDTH-bit operands plus carry-in,
//            DIGITS bits per clock, through a chain of DIGITS full-adder cells.
//            The carry is held in a register between steps, and a
//            start/busy/done handshake wraps the operation.
//            Optional subtract mode is enabled by the SERIAL_ADDER_SUB_EN macro.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module serial_adder #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 1
) (
  input  logic             i_w_clk,
  input  logic             i_w_reset,
  input  logic             i_w_start,
  input  logic [WIDTH-1:0] i_w_a,
  input  logic [WIDTH-1:0] i_w_b,
  input  logic             i_w_cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             i_w_sub,
`endif
  output logic             o_w_busy,
  output logic             o_w_done,
  output logic [WIDTH-1:0] o_w_s,
  output logic             o_w_cout,
  output logic             o_w_ovf
);

  localparam int c_n_steps = WIDTH / DIGITS;
  localparam int c_cnt_w   = (c_n_steps > 1) ? $clog2(c_n_steps) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_n_steps - 1);

  // Refuse to elaborate a configuration that cannot be split into whole digits.
  generate
    if (WIDTH < 1 || DIGITS < 1 || (WIDTH % DIGITS) != 0) begin : g_bad_cfg
      $error("serial_adder: WIDTH must be a positive multiple of DIGITS");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_carry;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_s;
  logic               r_cout;
  logic               r_ovf;
  logic               r_busy;
  logic               r_done;

  logic [WIDTH-1:0]   w_b_load;
  logic               w_cin_load;
  logic [DIGITS:0]    w_c;
  logic [DIGITS-1:0]  w_sum;
  logic [WIDTH-1:0]   w_s_next;

  // Subtraction is A + ~B + ~borrow, so the inversion happens once at capture.
`ifdef SERIAL_ADDER_SUB_EN
  assign w_b_load   = i_w_sub ? ~i_w_b : i_w_b;
  assign w_cin_load = i_w_sub ^ i_w_cin;
`else
  assign w_b_load   = i_w_b;
  assign w_cin_load = i_w_cin;
`endif

  // Ripple chain over the current digit; w_c[0] is the carry saved from the previous step.
  assign w_c[0] = r_carry;
  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_fa
      assign w_sum[i]   = r_a[i] ^ r_b[i] ^ w_c[i];
      assign w_c[i+1]   = (r_a[i] & r_b[i]) | (w_c[i] & (r_a[i] ^ r_b[i]));
    end
  endgenerate

  // New digit enters at the MSB end so that after N steps the result is aligned.
  generate
    if (WIDTH == DIGITS) begin : g_s_full
      assign w_s_next = w_sum;
    end else begin : g_s_shift
      assign w_s_next = {w_sum, r_s[WIDTH-1:DIGITS]};
    end
  endgenerate

  // Control FSM plus datapath registers; all outputs come straight from registers.
  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (i_w_start) begin
            r_a     <= i_w_a;
            r_b     <= w_b_load;
            r_carry <= w_cin_load;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> DIGITS;
          r_b     <= r_b >> DIGITS;
          r_s     <= w_s_next;
          r_carry <= w_c[DIGITS];
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == c_last) begin
            // The MSB sits in the top cell of the final digit.
            r_cout  <= w_c[DIGITS];
            r_ovf   <= w_c[DIGITS-1] ^ w_c[DIGITS];
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_w_busy = r_busy;
  assign o_w_done = r_done;
  assign o_w_s    = r_s;
  assign o_w_cout = r_cout;
  assign o_w_ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
//==============================================================================
// Module   : tb_serial_adder
// Brief    : Self-checking bench for serial_adder. Three instances
//            (8/1, 8/4, 1/1) share one stimulus stream; a cycle-level
//            arithmetic model predicts busy/done/result for each one.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_serial_adder;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       sub;

  logic       busy [3];
  logic       done [3];
  logic       cout [3];
  logic       ovf  [3];
  logic [7:0] s0;
  logic [7:0] s1;
  logic [0:0] s2;
  logic [7:0] act_s [3];

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Per-instance width and step count.
  int WID [3] = '{8, 8, 1};
  int NST [3] = '{8, 2, 1};

  // Model: ph = 0 idle, 1..N busy cycle index, N+1 done cycle.
  int ph  [3] = '{0, 0, 0};
  int ms  [3] = '{0, 0, 0};
  int mc  [3] = '{0, 0, 0};
  int mo  [3] = '{0, 0, 0};
  int pend_s [3];
  int pend_c [3];
  int pend_o [3];

  serial_adder #(.WIDTH(8), .DIGITS(1)) u_dut0 (
    .i_w_clk(clk), .i_w_reset(rst), .i_w_start(start),
    .i_w_a(a), .i_w_b(b), .i_w_cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .i_w_sub(sub),
`endif
    .o_w_busy(busy[0]), .o_w_done(done[0]), .o_w_s(s0),
    .o_w_cout(cout[0]), .o_w_ovf(ovf[0])
  );

  serial_adder #(.WIDTH(8), .DIGITS(4)) u_dut1 (
    .i_w_clk(clk), .i_w_reset(rst), .i_w_start(start),
    .i_w_a(a), .i_w_b(b), .i_w_cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .i_w_sub(sub),
`endif
    .o_w_busy(busy[1]), .o_w_done(done[1]), .o_w_s(s1),
    .o_w_cout(cout[1]), .o_w_ovf(ovf[1])
  );

  serial_adder #(.WIDTH(1), .DIGITS(1)) u_dut2 (
    .i_w_clk(clk), .i_w_reset(rst), .i_w_start(start),
    .i_w_a(a[0:0]), .i_w_b(b[0:0]), .i_w_cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .i_w_sub(sub),
`endif
    .o_w_busy(busy[2]), .o_w_done(done[2]), .o_w_s(s2),
    .o_w_cout(cout[2]), .o_w_ovf(ovf[2])
  );

  assign act_s[0] = s0;
  assign act_s[1] = s1;
  assign act_s[2] = {7'b0, s2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: widths, two's complement and signed overflow by sign rule.
  task automatic calc(input int w, input logic [7:0] ai, input logic [7:0] bi,
                      input logic ci, input logic si,
                      output int rs, output int rc, output int ro);
    int mask, av, bv, cv, full, sa, sb, ss;
    mask = (1 << w) - 1;
    av   = int'(ai) & mask;
    bv   = (si ? int'(~bi) : int'(bi)) & mask;
    cv   = (si ? int'(!ci) : int'(ci));
    full = av + bv + cv;
    rs   = full & mask;
    rc   = (full >> w) & 1;
    sa   = (av >> (w - 1)) & 1;
    sb   = (bv >> (w - 1)) & 1;
    ss   = (rs >> (w - 1)) & 1;
    ro   = ((sa == sb) && (ss != sa)) ? 1 : 0;
  endtask

  // Timing/result model advanced once per rising edge.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        ph[k] = 0; ms[k] = 0; mc[k] = 0; mo[k] = 0;
      end else if (ph[k] == 0 || ph[k] == NST[k] + 1) begin
        if (start) begin
          ph[k] = 1;
          calc(WID[k], a, b, cin, sub, pend_s[k], pend_c[k], pend_o[k]);
        end else begin
          ph[k] = 0;
        end
      end else if (ph[k] == NST[k]) begin
        ph[k] = NST[k] + 1;
        ms[k] = pend_s[k]; mc[k] = pend_c[k]; mo[k] = pend_o[k];
      end else begin
        ph[k] = ph[k] + 1;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        int eb, ed;
        eb = (ph[k] >= 1 && ph[k] <= NST[k]) ? 1 : 0;
        ed = (ph[k] == NST[k] + 1) ? 1 : 0;
        chk($sformatf("busy%0d", k), int'(busy[k]), eb);
        chk($sformatf("done%0d", k), int'(done[k]), ed);
        if (eb == 0) chk($sformatf("s%0d", k), int'(act_s[k]), ms[k]);
        chk($sformatf("cout%0d", k), int'(cout[k]), mc[k]);
        chk($sformatf("ovf%0d", k), int'(ovf[k]), mo[k]);
      end
    end
  end

  initial begin
    int mode;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy0", int'(busy[0]), 0);
    chk("rst_s0", int'(s0), 0);
    chk("rst_cout1", int'(cout[1]), 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // 0x7F + 0x01 + 0: signed overflow into 0x80.
    a = 8'h7F; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    repeat (2) @(negedge clk);
    chk("d1_done_u1", int'(done[1]), 1);
    chk("d1_s_u1", int'(s1), 8'h80);
    chk("d1_ovf_u1", int'(ovf[1]), 1);
    repeat (5) @(negedge clk);
    chk("d1_busy8_u0", int'(busy[0]), 1);
    @(negedge clk);
    chk("d1_done_u0", int'(done[0]), 1);
    chk("d1_s_u0", int'(s0), 8'h80);
    chk("d1_cout_u0", int'(cout[0]), 0);
    chk("d1_ovf_u0", int'(ovf[0]), 1);
    chk("d1_s_u2", int'(s2), 0);
    chk("d1_cout_u2", int'(cout[2]), 1);
    @(negedge clk);
    chk("d1_pulse_u0", int'(done[0]), 0);

    // 0xFF + 0x01 + 1 = 0x101.
    a = 8'hFF; b = 8'h01; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("d2_done_u1", int'(done[1]), 1);
    chk("d2_s_u1", int'(s1), 8'h01);
    chk("d2_cout_u1", int'(cout[1]), 1);
    chk("d2_ovf_u1", int'(ovf[1]), 0);
    repeat (7) @(negedge clk);
    chk("d2_s_u0", int'(s0), 8'h01);
    chk("d2_s_u2", int'(s2), 1);
    chk("d2_ovf_u2", int'(ovf[2]), 0);

`ifdef SERIAL_ADDER_SUB_EN
    a = 8'h05; b = 8'h07; cin = 1'b0; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("sub1_s_u1", int'(s1), 8'hFE);
    chk("sub1_cout_u1", int'(cout[1]), 0);
    chk("sub1_ovf_u1", int'(ovf[1]), 0);
    repeat (7) @(negedge clk);
    a = 8'h80; b = 8'h01; cin = 1'b0; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("sub2_s_u1", int'(s1), 8'h7F);
    chk("sub2_ovf_u1", int'(ovf[1]), 1);
    repeat (7) @(negedge clk);
    sub = 1'b0;
`endif

    // Start pulsed again mid-run must be ignored.
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hAA; b = 8'hAA; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("ign_done_u0", int'(done[0]), 1);
    chk("ign_s_u0", int'(s0), 8'h46);
    repeat (2) @(negedge clk);

    // Reset mid-run aborts with outputs cleared.
    a = 8'hF0; b = 8'h0F; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy_u0", int'(busy[0]), 0);
    chk("abort_s_u0", int'(s0), 0);
    chk("abort_cout_u0", int'(cout[0]), 0);
    repeat (10) @(negedge clk);

    // Randomised traffic: alternating sparse starts and held-high bursts.
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) mode = $urandom_range(0, 2);
      a   = 8'($urandom);
      b   = 8'($urandom);
      cin = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
      sub = 1'($urandom);
`endif
      case (mode)
        0:       start = ($urandom_range(0, 9) == 0);
        1:       start = 1'b1;
        default: start = ($urandom_range(0, 1) == 0);
      endcase
      rst = ($urandom_range(0, 149) == 0);
      @(negedge clk);
    end
    start = 1'b0; rst = 1'b0;
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
